// File: rtl/mini_ctrl_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mini_ctrl_unit_pkg                                          |
// | Desc   : Shared opcodes, instruction classes, FSM state encoding and |
// |          instruction-word field positions for the mini control unit. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package mini_ctrl_unit_pkg;

  // Opcode values (IR[15:12]); 0x0..0x7 are all ALU operations.
  localparam logic [3:0] OP_ALU_LAST = 4'h7;
  localparam logic [3:0] OP_LOADI    = 4'h8;
  localparam logic [3:0] OP_LOAD     = 4'h9;
  localparam logic [3:0] OP_STORE    = 4'hA;
  localparam logic [3:0] OP_BRANCH   = 4'hB;
  localparam logic [3:0] OP_HALT     = 4'hF;

  // Instruction classes produced by the opcode decoder.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOADI  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_NOP    = 3'd5,
    CLS_HALT   = 3'd6
  } instr_class_t;

  // FSM state encoding.
  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_REGREAD   = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  // Instruction-word field positions.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int SELD_MSB = 11;
  localparam int SELD_LSB = 9;
  localparam int SELA_MSB = 8;
  localparam int SELA_LSB = 6;
  localparam int SELB_MSB = 5;
  localparam int SELB_LSB = 3;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  // Classes whose result is written back to the register file.
  function automatic logic cls_writes_back(input instr_class_t c);
    return (c == CLS_ALU) || (c == CLS_LOADI) || (c == CLS_LOAD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mini_ctrl_unit_class_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : instr_class_dec                                             |
// | Desc   : Combinational opcode-to-class decoder with writeback flag.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module instr_class_dec
  import mini_ctrl_unit_pkg::*;
(
  input  logic [3:0]   i_opcode,
  output instr_class_t o_class,
  output logic         o_wb
);

  // Map opcode to class; unassigned opcodes 0xC..0xE fall through to NOP.
  always_comb begin
    o_class = CLS_NOP;
    if (i_opcode <= OP_ALU_LAST) begin
      o_class = CLS_ALU;
    end else begin
      case (i_opcode)
        OP_LOADI:  o_class = CLS_LOADI;
        OP_LOAD:   o_class = CLS_LOAD;
        OP_STORE:  o_class = CLS_STORE;
        OP_BRANCH: o_class = CLS_BRANCH;
        OP_HALT:   o_class = CLS_HALT;
        default:   o_class = CLS_NOP;
      endcase
    end
    o_wb = cls_writes_back(o_class);
  end

endmodule
`default_nettype wire

// File: rtl/mini_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mini_ctrl_unit                                              |
// | Desc   : Multi-cycle instruction sequencer: fetch, decode, register  |
// |          read, execute, memory, writeback, with memory-wait timeout. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mini_ctrl_unit
  import mini_ctrl_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_instr,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_pc_en,
  output logic        o_rf_en,
  output logic        o_rf_we,
  output logic [2:0]  o_selA,
  output logic [2:0]  o_selB,
  output logic [2:0]  o_selD,
  output logic [7:0]  o_imm,
  output logic        o_alu_en,
  output logic        o_branch,
  output logic        o_mem_we,
  output logic        o_halted,
  output logic        o_err
);

  localparam int unsigned   CW         = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] C_WAIT_MAX = CW'(MEM_TIMEOUT);

  logic [2:0]    r_state;
  logic [15:0]   r_ir;
  logic [CW-1:0] r_wait_cnt;

  logic          r_mem_req;
  logic          r_mem_we;
  logic          r_pc_en;
  logic          r_rf_en;
  logic          r_rf_we;
  logic          r_alu_en;
  logic          r_branch;
  logic          r_halted;
  logic          r_err;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_ir_load;
  logic          w_timeout;
  instr_class_t  w_cls;
  logic          w_wb;

  instr_class_dec u_dec (
    .i_opcode (r_ir[OPC_MSB:OPC_LSB]),
    .o_class  (w_cls),
    .o_wb     (w_wb)
  );

  // Next-state, wait-counter and timeout logic.
  // A wait state only counts (and only accepts ready) once the request is
  // actually visible on o_mem_req, which matters for the first FETCH after
  // reset where the registered request is still low.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_ir_load   = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_inc   = (r_wait_cnt == C_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + CW'(1);
    case (r_state)
      S_FETCH, S_MEMORY: begin
        if (r_mem_req) begin
          if (i_mem_ready) begin
            if (r_state == S_FETCH) begin
              w_state_nxt = S_DECODE;
              w_ir_load   = 1'b1;
            end else begin
              w_state_nxt = w_wb ? S_WRITEBACK : S_FETCH;
            end
          end else if (w_cnt_inc == C_WAIT_MAX) begin
            w_state_nxt = S_HALT;
            w_timeout   = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      S_DECODE: begin
        w_state_nxt = (w_cls == CLS_HALT) ? S_HALT : S_REGREAD;
      end
      S_REGREAD: begin
        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) begin
          w_state_nxt = S_MEMORY;
        end else if (w_wb) begin
          w_state_nxt = S_WRITEBACK;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
    end
  end

  // Instruction register, loaded only on an accepted fetch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= i_instr;
    end
  end

  // Strobes are registered from the next state so each one is glitch-free
  // and aligned with the state it belongs to; o_err is sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_pc_en   <= 1'b0;
      r_rf_en   <= 1'b0;
      r_rf_we   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_branch  <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_MEMORY);
      r_mem_we  <= (w_state_nxt == S_MEMORY) && (w_cls == CLS_STORE);
      r_pc_en   <= (w_state_nxt == S_DECODE);
      r_rf_en   <= (w_state_nxt == S_REGREAD) || (w_state_nxt == S_WRITEBACK);
      r_rf_we   <= (w_state_nxt == S_WRITEBACK);
      r_alu_en  <= (w_state_nxt == S_EXECUTE) && (w_cls == CLS_ALU);
      r_branch  <= (w_state_nxt == S_EXECUTE) && (w_cls == CLS_BRANCH);
      r_halted  <= (w_state_nxt == S_HALT);
      r_err     <= r_err | w_timeout;
    end
  end

  assign o_mem_req = r_mem_req;
  assign o_mem_we  = r_mem_we;
  assign o_pc_en   = r_pc_en;
  assign o_rf_en   = r_rf_en;
  assign o_rf_we   = r_rf_we;
  assign o_alu_en  = r_alu_en;
  assign o_branch  = r_branch;
  assign o_halted  = r_halted;
  assign o_err     = r_err;

  assign o_selD = r_ir[SELD_MSB:SELD_LSB];
  assign o_selA = r_ir[SELA_MSB:SELA_LSB];
  assign o_selB = r_ir[SELB_MSB:SELB_LSB];
  assign o_imm  = r_ir[IMM_MSB:IMM_LSB];

endmodule
`default_nettype wire

// File: tb/tb_mini_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mini_ctrl_unit                                           |
// | Desc   : Scoreboard bench for mini_ctrl_unit: per-cycle expected     |
// |          strobes are queued with stimulus and compared as consumed.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mini_ctrl_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_instr;
  logic        i_mem_ready;
  logic        o_mem_req, o_pc_en, o_rf_en, o_rf_we;
  logic [2:0]  o_selA, o_selB, o_selD;
  logic [7:0]  o_imm;
  logic        o_alu_en, o_branch, o_mem_we, o_halted, o_err;

  int n_checks = 0;
  int n_errors = 0;

  // One scoreboard entry per clock cycle: the ready/instr to present
  // during that cycle and the outputs expected in that cycle.
  typedef struct {
    logic        ready;
    logic [15:0] instr;
    logic [8:0]  exp;
    logic        chk_fld;
    logic [15:0] fld_src;
    string       tag;
  } step_t;

  step_t q[$];

  mini_ctrl_unit #(.MEM_TIMEOUT(15)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_instr     (i_instr),
    .i_mem_ready (i_mem_ready),
    .o_mem_req   (o_mem_req),
    .o_pc_en     (o_pc_en),
    .o_rf_en     (o_rf_en),
    .o_rf_we     (o_rf_we),
    .o_selA      (o_selA),
    .o_selB      (o_selB),
    .o_selD      (o_selD),
    .o_imm       (o_imm),
    .o_alu_en    (o_alu_en),
    .o_branch    (o_branch),
    .o_mem_we    (o_mem_we),
    .o_halted    (o_halted),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // Strobe vector order: req, we, pc, rf_en, rf_we, alu, branch, halted, err
  function automatic logic [8:0] st(input logic req, input logic we, input logic pc,
                                    input logic rfen, input logic rfwe, input logic alu,
                                    input logic br, input logic hlt, input logic err);
    return {req, we, pc, rfen, rfwe, alu, br, hlt, err};
  endfunction

  function automatic logic [8:0] act_vec();
    return {o_mem_req, o_mem_we, o_pc_en, o_rf_en, o_rf_we,
            o_alu_en, o_branch, o_halted, o_err};
  endfunction

  task automatic push(input logic rdy, input logic [15:0] ins, input logic [8:0] ex,
                      input logic chk, input logic [15:0] src, input string tag);
    step_t s;
    s.ready = rdy; s.instr = ins; s.exp = ex;
    s.chk_fld = chk; s.fld_src = src; s.tag = tag;
    q.push_back(s);
  endtask

  // Reference sequence for one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic push_instr(input logic [15:0] ins, input int fw, input int mw);
    logic [3:0] op;
    op = ins[15:12];
    for (int k = 0; k < fw; k++) push(1'b0, 16'hFFFF, st(1,0,0,0,0,0,0,0,0), 1'b0, 16'h0, "fetch_wait");
    push(1'b1, ins, st(1,0,0,0,0,0,0,0,0), 1'b0, 16'h0, "fetch");
    push(1'b0, 16'hFFFF, st(0,0,1,0,0,0,0,0,0), 1'b1, ins, "decode");
    if (op == 4'hF) return;
    push(1'b0, 16'hFFFF, st(0,0,0,1,0,0,0,0,0), 1'b1, ins, "regread");
    push(1'b0, 16'hFFFF, st(0,0,0,0,0, op <= 4'h7, op == 4'hB, 0,0), 1'b1, ins, "execute");
    if (op == 4'h9 || op == 4'hA) begin
      for (int k = 0; k < mw; k++)
        push(1'b0, 16'hFFFF, st(1, op == 4'hA, 0,0,0,0,0,0,0), 1'b1, ins, "memory_wait");
      push(1'b1, 16'hFFFF, st(1, op == 4'hA, 0,0,0,0,0,0,0), 1'b1, ins, "memory");
    end
    if (op <= 4'h9) push(1'b0, 16'hFFFF, st(0,0,0,1,1,0,0,0,0), 1'b1, ins, "writeback");
  endtask

  // Scoreboard consumer: one entry per cycle, sampled at the falling edge.
  task automatic drain();
    step_t s;
    logic [8:0] a;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge i_clk);
      a = act_vec();
      n_checks++;
      if (a !== s.exp) begin
        n_errors++;
        $display("FAIL %s strobes: got %b expected %b (t=%0t)", s.tag, a, s.exp, $time);
      end
      if (s.chk_fld) begin
        n_checks++;
        if ({o_selD, o_selA, o_selB, o_imm} !==
            {s.fld_src[11:9], s.fld_src[8:6], s.fld_src[5:3], s.fld_src[7:0]}) begin
          n_errors++;
          $display("FAIL %s fields: got D=%0d A=%0d B=%0d imm=%h expected D=%0d A=%0d B=%0d imm=%h",
                   s.tag, o_selD, o_selA, o_selB, o_imm,
                   s.fld_src[11:9], s.fld_src[8:6], s.fld_src[5:3], s.fld_src[7:0]);
        end
      end
      i_mem_ready = s.ready;
      i_instr     = s.instr;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_mem_ready = 1'b0; i_instr = 16'hFFFF;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mem_ready = 1'b1; i_instr = 16'h1298;
    @(negedge i_clk);
    n_checks++;
    if (act_vec() !== 9'b0) begin
      n_errors++; $display("FAIL reset_strobes: got %b expected %b", act_vec(), 9'b0);
    end
    n_checks++;
    if ({o_selD, o_selA, o_selB, o_imm} !== 17'b0) begin
      n_errors++; $display("FAIL reset_fields: got %h expected 0", {o_selD, o_selA, o_selB, o_imm});
    end
    i_mem_ready = 1'b0; i_instr = 16'hFFFF;
    @(negedge i_clk);
    i_rst = 1'b0;
    push_instr(16'h1298, 0, 0);
    for (int k = 0; k < 4; k++) push(1'b0, 16'hFFFF, st(1,0,0,0,0,0,0,0,0), 1'b0, 16'h0, "fetch_wait");
    drain();
    // asynchronous reset mid-wait: request and IR must clear without a clock edge
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if (act_vec() !== 9'b0) begin
      n_errors++; $display("FAIL reset_midwait_strobes: got %b expected %b", act_vec(), 9'b0);
    end
    n_checks++;
    if ({o_selD, o_selA, o_selB, o_imm} !== 17'b0) begin
      n_errors++; $display("FAIL reset_midwait_ir: got %h expected 0", {o_selD, o_selA, o_selB, o_imm});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    push_instr(16'h8A7F, 0, 0);
    drain();
  endtask

  task automatic test_alu();
    do_reset();
    push_instr(16'h1298, 0, 0);
    push_instr(16'h0000, 0, 0);
    drain();
  endtask

  task automatic test_loadi();
    do_reset();
    push_instr(16'h8A7F, 0, 0);
    drain();
  endtask

  task automatic test_store_wait();
    do_reset();
    push_instr(16'hA000, 0, 3);
    push_instr(16'hA5C3, 1, 0);
    drain();
  endtask

  task automatic test_load();
    do_reset();
    push_instr(16'h9E40, 2, 1);
    push_instr(16'h9123, 0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_instr(16'hB123, 0, 0);
    push_instr(16'hC000, 0, 0);
    push_instr(16'hD7AA, 1, 0);
    push_instr(16'hE055, 0, 0);
    push_instr(16'h7FFF, 0, 0);
    push_instr(16'h9E40, 0, 2);
    push_instr(16'h8001, 0, 0);
    drain();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 15; k++) push(1'b0, 16'h1298, st(1,0,0,0,0,0,0,0,0), 1'b0, 16'h0, "timeout_wait");
    for (int k = 0; k < 6; k++) push(1'b1, 16'h1298, st(0,0,0,0,0,0,0,1,1), 1'b1, 16'h0, "timeout_halt");
    drain();
    // ready in the 15th wait cycle wins: no error, instruction completes
    do_reset();
    push_instr(16'h1298, 14, 0);
    push_instr(16'hB000, 0, 0);
    drain();
  endtask

  task automatic test_halt();
    do_reset();
    push_instr(16'h1298, 0, 0);
    push_instr(16'hF000, 0, 0);
    for (int k = 0; k < 20; k++) push(1'b1, 16'h1298, st(0,0,0,0,0,0,0,1,0), 1'b1, 16'hF000, "halt_hold");
    drain();
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (act_vec() !== 9'b0) begin
      n_errors++; $display("FAIL halt_reset_strobes: got %b expected %b", act_vec(), 9'b0);
    end
    i_mem_ready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    push_instr(16'h8A7F, 0, 0);
    drain();
  endtask

  task automatic test_reset_wb();
    do_reset();
    push_instr(16'h1298, 0, 0);
    void'(q.pop_back());
    drain();
    @(negedge i_clk);
    n_checks++;
    if (act_vec() !== st(0,0,0,1,1,0,0,0,0)) begin
      n_errors++; $display("FAIL wb_before_reset: got %b expected %b", act_vec(), st(0,0,0,1,1,0,0,0,0));
    end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_rf_en, o_rf_we} !== 2'b00) begin
      n_errors++; $display("FAIL wb_reset_drop: got rf_en/we=%b expected 00", {o_rf_en, o_rf_we});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (act_vec() !== 9'b0) begin
        n_errors++; $display("FAIL wb_reset_hold: got %b expected %b", act_vec(), 9'b0);
      end
    end
    i_rst = 1'b0;
    push_instr(16'hC000, 0, 0);
    drain();
  endtask

  initial begin
    i_rst = 1'b1; i_mem_ready = 1'b0; i_instr = 16'hFFFF;
    test_reset();
    test_alu();
    test_loadi();
    test_store_wait();
    test_load();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_reset_wb();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mini_ctrl_unit.md
MINI_CTRL_UNIT -- requirements
Module: mini_ctrl_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of consecutive cycles spent waiting for i_mem_ready before an error halt.
REQ-002 SHALL use one clock and asynchronous active-high reset: i_clk  in  1  rising-edge clock; i_rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have i_instr  in  16  instruction word from memory, valid when i_mem_ready=1 in FETCH.
REQ-004 SHALL have i_mem_ready  in  1  memory acknowledge for the current o_mem_req.
REQ-005 SHALL have o_mem_req  out  1  memory request, held high while waiting in FETCH or MEMORY.
REQ-006 SHALL have o_pc_en  out  1  one-cycle program-counter advance pulse.
REQ-007 SHALL have o_rf_en, o_rf_we  out  1 each  register-file enable and write-enable.
REQ-008 SHALL have o_selA, o_selB, o_selD  out  3 each  register-file addresses.
REQ-009 SHALL have o_imm  out  8  immediate field; o_alu_en  out  1  ALU strobe; o_branch  out  1  branch strobe; o_mem_we  out  1  store qualifier; o_halted  out  1; o_err  out  1.

Function
REQ-010 SHALL decode fields from the instruction register (IR): opcode=IR[15:12], selD=IR[11:9], selA=IR[8:6], selB=IR[5:3], imm=IR[7:0].
REQ-011 SHALL classify opcodes as follows: 0x0-0x7 ALU (writes back); 0x8 LOADI (writes back); 0x9 LOAD (memory, writes back); 0xA STORE (memory, no writeback); 0xB BRANCH (no writeback); 0xF HALT; 0xC-0xE NOP (no writeback).
REQ-012 SHALL implement the states FETCH, DECODE, REGREAD, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-013 FETCH: SHALL assert o_mem_req; when i_mem_ready=1, SHALL load IR<=i_instr, pulse o_pc_en for one cycle, and move to DECODE.
REQ-014 DECODE: SHALL move to HALT if the opcode is HALT, otherwise to REGREAD.
REQ-015 REGREAD: SHALL assert o_rf_en=1 and o_rf_we=0, then move to EXECUTE.
REQ-016 EXECUTE: SHALL pulse o_alu_en for the ALU class; SHALL pulse o_branch for BRANCH.
REQ-017 EXECUTE transitions: SHALL go to MEMORY for LOAD/STORE, to WRITEBACK for ALU/LOADI, and otherwise to FETCH.
REQ-018 MEMORY: SHALL assert o_mem_req, with o_mem_we=1 for STORE only; on i_mem_ready=1, SHALL go to WRITEBACK for LOAD and to FETCH for STORE.
REQ-019 WRITEBACK: SHALL assert o_rf_en=1 and o_rf_we=1 for exactly one cycle, then go to FETCH.
REQ-020 o_selA/o_selB/o_selD/o_imm SHALL be driven from IR and remain stable from DECODE through the end of the instruction.
REQ-021 Wait counter: SHALL count cycles in FETCH/MEMORY with i_mem_ready=0; SHALL clear on ready or on state exit; SHALL saturate and not wrap.
REQ-022 Timeout: SHALL move to HALT and set o_err=1 when the wait counter reaches MEM_TIMEOUT with ready still low; a ready arriving in that same cycle SHALL win and no error is raised.
REQ-023 HALT: SHALL hold o_halted=1 with all strobes 0; SHALL leave HALT only on reset; o_err SHALL be sticky until reset.
REQ-024 o_rf_we SHALL never be 1 while o_rf_en=0.
REQ-025 All strobes SHALL be registered outputs of the state machine and glitch-free.
REQ-026 Total latency with ready immediate: ALU/LOADI SHALL take 5 cycles; BRANCH/NOP SHALL take 4; STORE SHALL take 5; LOAD SHALL take 6.

Reset
REQ-027 Asserting i_rst at any time, including mid-instruction or mid-wait, SHALL immediately set state=FETCH, IR=0, wait counter=0, and all outputs=0, including o_err and o_halted.
REQ-028 After i_rst deasserts, the first rising edge SHALL begin FETCH with o_mem_req=1.

Structure
REQ-029 A shared package SHALL hold the opcode constants, instruction-class encoding, state encoding and field bit positions.
REQ-030 The combinational opcode-to-class decoder SHALL be a sub-module, instr_class_dec.

Verification
REQ-031 Reset, then i_mem_ready=1 with i_instr=0x1298 -> o_pc_en pulse; selD=1, selA=2, selB=3; o_rf_en in REGREAD; o_alu_en in EXECUTE; o_rf_we=1 in WRITEBACK; back in FETCH on cycle 6.
REQ-032 i_instr=0x8A7F -> o_selD=5, o_imm=0x7F, one WRITEBACK cycle, no o_mem_req after FETCH.
REQ-033 STORE 0xA000 with i_mem_ready low for 3 MEMORY cycles -> o_mem_req and o_mem_we held 4 cycles, no WRITEBACK, then FETCH.
REQ-034 i_mem_ready held 0 in FETCH -> after 15 wait cycles, HALT with o_err=1 and o_halted=1; repeat with ready in that 15th cycle -> no error.
REQ-035 i_instr=0xF000 -> HALT after DECODE; o_halted stays 1 for 20 cycles; i_rst -> all outputs 0, FETCH resumes.
REQ-036 i_rst asserted during WRITEBACK -> o_rf_we drops immediately and no further write strobe follows.
